// File: rtl/reg_file_pkg.sv
// Shared CPU register-file parameters and small helpers used by the
// register file and its write decoder.
package reg_file_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;

    // A read port forwards write data only for a live, non-x0 write to the same register.
    function automatic logic bypass_hit(
        input logic      we,
        input logic      rst,
        input reg_addr_t wa,
        input reg_addr_t ra
    );
        return we && !rst && (wa != '0) && (wa == ra);
    endfunction

endpackage

// File: rtl/reg_file_write_decoder.sv
// One-hot write-enable decoder: bit i is set when the write port targets register i.
module write_decoder
    import reg_file_pkg::*;
#(
    parameter int DEPTH = NREGS,
    parameter int AW    = REG_AW
) (
    input  logic [AW-1:0]    a_i,
    input  logic             we_i,
    output logic [DEPTH-1:0] en_o
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_dec
        assign en_o[i] = we_i && (a_i == AW'(i));
    end

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with x0 hardwired to zero and
// same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] A1,
    input  logic [REG_AW-1:0] A2,
    input  logic [REG_AW-1:0] A3,
    input  logic [WIDTH-1:0]  WD3,
    input  logic              WE3,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);

    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    write_decoder #(
        .DEPTH (DEPTH),
        .AW    (REG_AW)
    ) u_dec (
        .a_i  (A3),
        .we_i (WE3),
        .en_o (wr_en)
    );

    // Slot 0 is never loaded except by reset; reads of x0 are forced to zero anyway.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (reset)
                regs_d[i] = '0;
            else if ((i != 0) && wr_en[i])
                regs_d[i] = WD3;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= regs_d[i];
    end

    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs_q[A1];
        RD2 = (A2 == '0) ? '0 : regs_q[A2];
        if (bypass_hit(WE3, reset, A3, A1)) RD1 = WD3;
        if (bypass_hit(WE3, reset, A3, A2)) RD2 = WD3;
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven check of reg_file reads, writes, x0, forwarding and reset.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1, RD2;

    int total = 0;
    int bad   = 0;

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WD3   (WD3),
        .WE3   (WE3),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected contents after the fill loop: x_i = A5A5_0000 + i.
        vecs[0] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd3,  32'h0,         32'hA5A5_0003};
        vecs[2] = '{1'b1, 5'd5,  32'h1111_1111, 5'd5,  5'd6,  32'h1111_1111, 32'hA5A5_0006};
        vecs[3] = '{1'b1, 5'd5,  32'h2222_2222, 5'd5,  5'd5,  32'h2222_2222, 32'h2222_2222};
        vecs[4] = '{1'b0, 5'd5,  32'h0,         5'd5,  5'd5,  32'h2222_2222, 32'h2222_2222};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd30, 5'd31, 32'hA5A5_001E, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'hCAFE_F00D, 32'hA5A5_0001};

        reset = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1[%0d]", i), RD1, 32'h0);
            check($sformatf("reset_rd2[%0d]", 31 - i), RD2, 32'h0);
        end

        for (int i = 1; i < 32; i++) begin
            WE3 = 1'b1; A3 = 5'(i); WD3 = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        WE3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(i);
            #1;
            check($sformatf("fill_rd1[%0d]", i), RD1, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
            check($sformatf("fill_rd2[%0d]", i), RD2, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
        end

        // Combinational outputs checked before the edge that commits each vector.
        for (int v = 0; v < 7; v++) begin
            WE3 = vecs[v].we; A3 = vecs[v].a3; WD3 = vecs[v].wd;
            A1 = vecs[v].a1;  A2 = vecs[v].a2;
            #1;
            check($sformatf("vec%0d_rd1", v), RD1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), RD2, vecs[v].exp2);
            tick();
        end

        // Write-disabled cycles with live address/data must leave x9 alone.
        WE3 = 1'b0; A3 = 5'd9; WD3 = 32'h1234_5678; A1 = 5'd9; A2 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold_x9_c%0d", c), RD1, 32'hA5A5_0009);
            tick();
        end
        check("hold_x9_end", RD2, 32'hA5A5_0009);

        // Reset beats a coincident write and suppresses forwarding.
        reset = 1'b1; WE3 = 1'b1; A3 = 5'd7; WD3 = 32'hDEAD_BEEF; A1 = 5'd7; A2 = 5'd9;
        #1;
        check("rst_nobypass_rd1", RD1, 32'hA5A5_0007);
        check("rst_stored_rd2", RD2, 32'hA5A5_0009);
        tick();
        check("rst_x7_cleared", RD1, 32'h0);
        check("rst_x9_cleared", RD2, 32'h0);

        // First edge after reset release takes a write.
        reset = 1'b0; WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h0000_0055; A1 = 5'd7; A2 = 5'd8;
        tick();
        WE3 = 1'b0;
        #1;
        check("post_rst_x7", RD1, 32'h0000_0055);
        check("post_rst_x8", RD2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register.
REQ-002 SHALL have parameter DEPTH, default 32: register count; address width is log2(DEPTH) = 5.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port A1, input, 5: read port 1 address.
REQ-006 SHALL have port A2, input, 5: read port 2 address.
REQ-007 SHALL have port A3, input, 5: write port address.
REQ-008 SHALL have port WD3, input, WIDTH: write data.
REQ-009 SHALL have port WE3, input, 1: write enable.
REQ-010 SHALL have port RD1, output, WIDTH: read port 1 data.
REQ-011 SHALL have port RD2, output, WIDTH: read port 2 data.

Function
REQ-012 SHALL hold DEPTH registers of WIDTH bits, x1..x31 writable.
REQ-013 SHALL write WD3 into register A3 on a rising clk edge when WE3=1, reset=0, and A3!=0.
REQ-014 SHALL derive per-register write enables from A3/WE3 as a one-hot 32-bit vector, bit i = WE3 & (A3==i).
REQ-015 SHALL ignore writes to A3=0; x0 reads as 0 at all times.
REQ-016 SHALL read combinationally: RD1 = reg[A1], RD2 = reg[A2], zero-cycle latency, no clock dependency.
REQ-017 SHALL bypass write data: if WE3=1, A3!=0, and A1==A3, RD1 SHALL equal WD3 in the same cycle; likewise RD2 for A2==A3.
REQ-018 SHALL NOT bypass when A3=0; reading address 0 SHALL return 0 even with WE3=1, WD3!=0.
REQ-019 SHALL allow both read ports to address the same register simultaneously, each returning identical data.
REQ-020 SHALL hold all register contents unchanged when WE3=0.
REQ-021 SHALL treat X/Z on A1/A2 only as affecting the corresponding RD output, never register state.

Reset
REQ-022 SHALL clear all registers to 0 on a rising clk edge when reset=1.
REQ-023 SHALL give reset priority over a coincident write; the write is discarded.
REQ-024 SHALL suppress bypass while reset=1: RD1/RD2 reflect stored values (0 after the first reset edge).
REQ-025 SHALL resume normal writes on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL take WIDTH, DEPTH, and the register-address width constant from the shared CPU parameter package.
REQ-027 SHALL instantiate write_decoder as its single sub-module to generate the one-hot enable vector.
REQ-028 SHALL implement storage as an array of WIDTH-bit flops, each gated by one write_decoder enable bit.

Verification
REQ-029 SHALL check: reset 1 cycle, then read all 32 addresses on both ports -> every RD = 0.
REQ-030 SHALL check: write 32'hA5A5_0000+i to xi for i=1..31, then read each back on RD1 and RD2 -> value matches; x0 = 0.
REQ-031 SHALL check: WE3=1, A3=0, WD3=32'hFFFF_FFFF, A1=0 -> RD1=0 that cycle and after the edge.
REQ-032 SHALL check: x5=32'h1111_1111 stored; WE3=1, A3=5, WD3=32'h2222_2222, A1=5, A2=5 -> RD1=RD2=32'h2222_2222 before the edge.
REQ-033 SHALL check: reset=1 with WE3=1, A3=7, WD3=32'hDEAD_BEEF -> x7=0 after the edge.
REQ-034 SHALL check: WE3=0, A3=9, WD3=32'h1234_5678 over 3 cycles -> x9 unchanged.
